// File: rtl/task2b.sv
// RC4 keystream generator and decryptor: walks S with the PRGA, XORs each
// keystream byte with the encrypted ROM byte and writes the result to RAM.
//
// state  | meaning
// IDLE   | waiting for start, S bus released
// RD_SI  | address S[i]
// LT_SI  | latch si, j += si
// RD_SJ  | address S[j]
// LT_SJ  | latch sj
// WR_SI  | S[i] <= sj
// WR_SJ  | S[j] <= si
// RD_F   | address S[si+sj] and ROM[k]
// LT_F   | latch f and encrypted byte
// WR_OUT | RAM[k] <= f ^ enc
// DONE   | one-cycle completion strobe
module task2b #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] s_address,
  output logic [7:0] s_data_out,
  output logic       s_wr_en,
  input  logic [7:0] s_data_in,
  output logic [4:0] rom_address,
  input  logic [7:0] rom_data,
  output logic [4:0] ram_address,
  output logic [7:0] ram_data,
  output logic       ram_wr_en,
  output logic       task_on,
  output logic       fin_strobe
);

  localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, RD_SI, LT_SI, RD_SJ, LT_SJ, WR_SI, WR_SJ, RD_F, LT_F, WR_OUT, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d;
  logic [7:0] si_q, si_d, sj_q, sj_d;
  logic [7:0] f_q, f_d, enc_q, enc_d;
  logic [4:0] k_q, k_d;

  logic [7:0] s_address_q, s_address_d;
  logic [7:0] s_data_out_q, s_data_out_d;
  logic       s_wr_en_q, s_wr_en_d;
  logic [4:0] rom_address_q, rom_address_d;
  logic [4:0] ram_address_q, ram_address_d;
  logic [7:0] ram_data_q, ram_data_d;
  logic       ram_wr_en_q, ram_wr_en_d;
  logic       task_on_q, task_on_d;
  logic       fin_strobe_q, fin_strobe_d;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    f_d     = f_q;
    enc_d   = enc_q;
    k_d     = k_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_SI;
          i_d     = 8'd1;
          j_d     = 8'd0;
          k_d     = 5'd0;
        end
      end
      RD_SI:  state_d = LT_SI;
      LT_SI: begin
        si_d    = s_data_in;
        j_d     = j_q + s_data_in;
        state_d = RD_SJ;
      end
      RD_SJ:  state_d = LT_SJ;
      LT_SJ: begin
        sj_d    = s_data_in;
        state_d = WR_SI;
      end
      WR_SI:  state_d = WR_SJ;
      WR_SJ:  state_d = RD_F;
      RD_F:   state_d = LT_F;
      LT_F: begin
        f_d     = s_data_in;
        enc_d   = rom_data;
        state_d = WR_OUT;
      end
      WR_OUT: begin
        if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 5'd1;
          i_d     = i_q + 8'd1;
          state_d = RD_SI;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    s_address_d   = 8'd0;
    s_data_out_d  = 8'd0;
    s_wr_en_d     = 1'b0;
    rom_address_d = 5'd0;
    ram_address_d = 5'd0;
    ram_data_d    = 8'd0;
    ram_wr_en_d   = 1'b0;
    fin_strobe_d  = 1'b0;
    task_on_d     = (state_d != IDLE);

    case (state_d)
      RD_SI: s_address_d = i_d;
      RD_SJ: s_address_d = j_d;
      WR_SI: begin
        s_address_d  = i_d;
        s_data_out_d = sj_d;
        s_wr_en_d    = 1'b1;
      end
      WR_SJ: begin
        s_address_d  = j_d;
        s_data_out_d = si_d;
        s_wr_en_d    = 1'b1;
      end
      RD_F: begin
        s_address_d   = si_d + sj_d;
        rom_address_d = k_d;
      end
      WR_OUT: begin
        ram_address_d = k_d;
        ram_data_d    = f_d ^ enc_d;
        ram_wr_en_d   = 1'b1;
      end
      DONE:    fin_strobe_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      i_q           <= 8'd0;
      j_q           <= 8'd0;
      si_q          <= 8'd0;
      sj_q          <= 8'd0;
      f_q           <= 8'd0;
      enc_q         <= 8'd0;
      k_q           <= 5'd0;
      s_address_q   <= 8'd0;
      s_data_out_q  <= 8'd0;
      s_wr_en_q     <= 1'b0;
      rom_address_q <= 5'd0;
      ram_address_q <= 5'd0;
      ram_data_q    <= 8'd0;
      ram_wr_en_q   <= 1'b0;
      task_on_q     <= 1'b0;
      fin_strobe_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      si_q          <= si_d;
      sj_q          <= sj_d;
      f_q           <= f_d;
      enc_q         <= enc_d;
      k_q           <= k_d;
      s_address_q   <= s_address_d;
      s_data_out_q  <= s_data_out_d;
      s_wr_en_q     <= s_wr_en_d;
      rom_address_q <= rom_address_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wr_en_q   <= ram_wr_en_d;
      task_on_q     <= task_on_d;
      fin_strobe_q  <= fin_strobe_d;
    end
  end

  assign s_address   = s_address_q;
  assign s_data_out  = s_data_out_q;
  assign s_wr_en     = s_wr_en_q;
  assign rom_address = rom_address_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wr_en   = ram_wr_en_q;
  assign task_on     = task_on_q;
  assign fin_strobe  = fin_strobe_q;

endmodule

// File: tb/tb_task2b.sv
// Bench for task2b: models S/ROM/RAM memories and checks against a plain
// software RC4 PRGA, including timing, restart immunity and mid-run reset.
module tb_task2b;
  localparam int MSG_LEN = 32;
  localparam int RUN_CYC = 9 * MSG_LEN;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] s_address, s_data_out, s_q, rom_q, ram_data;
  logic       s_wr_en, ram_wr_en, task_on, fin_strobe;
  logic [4:0] rom_address, ram_address;

  task2b #(.MSG_LEN(MSG_LEN)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_address(s_address), .s_data_out(s_data_out), .s_wr_en(s_wr_en),
    .s_data_in(s_q), .rom_address(rom_address), .rom_data(rom_q),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wr_en(ram_wr_en),
    .task_on(task_on), .fin_strobe(fin_strobe)
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem [0:255];
  logic [7:0] s_init [0:255];
  logic [7:0] s_snap [0:255];
  logic [7:0] rom [0:31];
  logic [7:0] ram_mem [0:31];
  logic [7:0] exp_out [0:31];
  logic [7:0] swr_addr [0:1023];
  logic [7:0] swr_data [0:1023];
  logic       load_s = 1'b0;
  int         ram_wr_cnt = 0;
  int         swr_n = 0;

  // Synchronous memories with one-clock read latency; S is snapshotted at the
  // byte-2 RAM write so the post-swap state of that byte can be inspected.
  always @(posedge clk) begin
    if (load_s) s_mem <= s_init;
    else if (s_wr_en) s_mem[s_address] <= s_data_out;
    s_q   <= s_mem[s_address];
    rom_q <= rom[rom_address];
    if (ram_wr_en) begin
      ram_mem[ram_address] <= ram_data;
      ram_wr_cnt <= ram_wr_cnt + 1;
      if (ram_address == 5'd2) s_snap <= s_mem;
    end
    if (s_wr_en) begin
      swr_addr[swr_n[9:0]] <= s_address;
      swr_data[swr_n[9:0]] <= s_data_out;
      swr_n <= swr_n + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {26'd0, s_address, s_data_out, s_wr_en, rom_address, ram_address,
            ram_data, ram_wr_en, task_on, fin_strobe};
  endfunction

  task automatic model_run();
    logic [7:0] S [0:255];
    logic [7:0] i, j, si, sj, t;
    for (int x = 0; x < 256; x++) S[x] = s_init[x];
    i = 8'd0;
    j = 8'd0;
    for (int k = 0; k < MSG_LEN; k++) begin
      i = i + 8'd1;
      si = S[i];
      j = j + si;
      sj = S[j];
      S[i] = sj;
      S[j] = si;
      t = si + sj;
      exp_out[k] = S[t] ^ rom[k];
    end
  endtask

  task automatic load_s_mem();
    @(negedge clk);
    load_s = 1'b1;
    @(negedge clk);
    load_s = 1'b0;
  endtask

  task automatic compare_ram(input string name);
    int bad = 0;
    int first = -1;
    for (int k = 0; k < MSG_LEN; k++) begin
      if (ram_mem[k] !== exp_out[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    check($sformatf("%s ram bytes vs model (first bad %0d)", name, first), bad, 0);
  endtask

  int run_lat, ton_bad, run_wr;

  task automatic do_run(input int hold_at, input int hold_len, input int rst_at);
    int wr0;
    wr0 = ram_wr_cnt;
    run_lat = -1;
    ton_bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= RUN_CYC + 20; n++) begin
      @(negedge clk);
      start = (hold_len > 0 && n >= hold_at && n < hold_at + hold_len);
      if (n == rst_at) begin
        rst = 1'b0;
        #1;
        check("outputs during mid-run reset", all_outs(), 64'd0);
        break;
      end
      @(posedge clk);
      #1;
      if (!task_on) ton_bad++;
      if (fin_strobe) begin
        run_lat = n;
        break;
      end
    end
    start = 1'b0;
    run_wr = ram_wr_cnt - wr0;
  endtask

  task automatic full_run(input string name, input int hold_at, input int hold_len);
    load_s_mem();
    model_run();
    do_run(hold_at, hold_len, 0);
    check({name, " fin_strobe latency"}, run_lat, RUN_CYC);
    check({name, " ram write count"}, run_wr, MSG_LEN);
    check({name, " task_on low during run"}, ton_bad, 0);
    @(posedge clk);
    #1;
    check({name, " fin/task_on after DONE"}, {fin_strobe, task_on}, 2'b00);
    compare_ram(name);
  endtask

  typedef struct {
    bit         is_s;
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [6];
  int         sw0, fin_seen, ton_seen, r;
  logic [7:0] key [3];
  logic [7:0] jk, tmp;

  initial begin
    vecs[0] = '{1'b0, 8'd0, 8'h02};
    vecs[1] = '{1'b0, 8'd1, 8'h05};
    vecs[2] = '{1'b0, 8'd2, 8'h07};
    vecs[3] = '{1'b1, 8'd2, 8'h03};
    vecs[4] = '{1'b1, 8'd3, 8'h05};
    vecs[5] = '{1'b1, 8'd5, 8'h02};

    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int k = 0; k < 32; k++) rom[k] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("outputs in reset", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle after reset release", {task_on, fin_strobe}, 2'b00);

    // Identity S, zero ROM: raw keystream.
    full_run("identity/zero", 0, 0);
    for (int v = 0; v < 6; v++) begin
      check($sformatf("%s[%0d]", vecs[v].is_s ? "S" : "ram", vecs[v].addr),
            vecs[v].is_s ? s_snap[vecs[v].addr] : ram_mem[vecs[v].addr[4:0]],
            vecs[v].exp);
    end

    // ROM[0]=FF, first swap has i=j=1.
    rom[0] = 8'hFF;
    sw0 = swr_n;
    full_run("rom0=ff", 0, 0);
    check("ram[0] with rom0=ff", ram_mem[0], 8'hFD);
    check("first S write i=j=1", {swr_addr[sw0[9:0]], swr_data[sw0[9:0]]}, 16'h0101);
    check("second S write i=j=1", {swr_addr[10'(sw0 + 1)], swr_data[10'(sw0 + 1)]}, 16'h0101);
    rom[0] = 8'h00;

    // start held high mid-run must not restart.
    full_run("start held", 50, 20);

    // Mid-run reset, then a clean run.
    load_s_mem();
    do_run(0, 0, 100);
    fin_seen = 0;
    ton_seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      fin_seen += int'(fin_strobe);
      check("outputs held in reset", all_outs(), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      fin_seen += int'(fin_strobe);
      ton_seen += int'(task_on);
    end
    check("fin_strobe after mid-run reset", fin_seen, 0);
    check("task_on waiting after reset", ton_seen, 0);
    for (int k = 0; k < 32; k++) rom[k] = 8'($urandom);
    full_run("after reset", 0, 0);

    // KSA with key 00 02 49, then PRGA over a random encrypted message.
    key[0] = 8'h00;
    key[1] = 8'h02;
    key[2] = 8'h49;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    jk = 8'd0;
    for (int x = 0; x < 256; x++) begin
      jk = jk + s_init[x] + key[x % 3];
      tmp = s_init[x];
      s_init[x] = s_init[jk];
      s_init[jk] = tmp;
    end
    for (int k = 0; k < 32; k++) rom[k] = 8'($urandom);
    full_run("key 000249 chain", 0, 0);

    // Random permutations of S with random ciphertext.
    for (int it = 0; it < 3; it++) begin
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
      for (int x = 255; x > 0; x--) begin
        r = int'($urandom_range(x, 0));
        tmp = s_init[x];
        s_init[x] = s_init[r];
        s_init[r] = tmp;
      end
      for (int k = 0; k < 32; k++) rom[k] = 8'($urandom);
      full_run($sformatf("random %0d", it), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/task2b.md
TASK2B -- requirements
Module: task2b

Interface
REQ-001 The block SHALL have parameter MSG_LEN, default 32, giving the number of message bytes decrypted per run (range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (rst=0 resets).
REQ-004 The block SHALL have port start, input, 1 bit: start pulse, sampled only in IDLE; normally driven by task2a fin_strobe.
REQ-005 The block SHALL have port s_address, output, 8 bits: S memory address.
REQ-006 The block SHALL have port s_data_out, output, 8 bits: S memory write data.
REQ-007 The block SHALL have port s_wr_en, output, 1 bit: S memory write enable.
REQ-008 The block SHALL have port s_data_in, input, 8 bits: S memory q, with one-clock synchronous read latency.
REQ-009 The block SHALL have port rom_address, output, 5 bits: encrypted-message ROM address.
REQ-010 The block SHALL have port rom_data, input, 8 bits: ROM q, with one-clock synchronous read latency.
REQ-011 The block SHALL have port ram_address, output, 5 bits: decrypted-message RAM address.
REQ-012 The block SHALL have port ram_data, output, 8 bits: decrypted-message RAM write data.
REQ-013 The block SHALL have port ram_wr_en, output, 1 bit: decrypted-message RAM write enable.
REQ-014 The block SHALL have port task_on, output, 1 bit: high while the block owns the S memory bus (any state except IDLE).
REQ-015 The block SHALL have port fin_strobe, output, 1 bit: one-cycle pulse marking completion.

Function
REQ-016 The block SHALL implement the RC4 PRGA over S: i=0, j=0; then for k=0..MSG_LEN-1: i=i+1; si=S[i]; j=j+si; sj=S[j]; S[i]=sj; S[j]=si; f=S[si+sj]; out[k]=f XOR enc[k].
REQ-017 All i, j and index sums SHALL be 8-bit modulo-256 arithmetic; k SHALL be a 5-bit counter.
REQ-018 The FSM states SHALL be IDLE, RD_SI, LT_SI, RD_SJ, LT_SJ, WR_SI, WR_SJ, RD_F, LT_F, WR_OUT and DONE.
REQ-019 IDLE SHALL go to RD_SI when start=1, clearing i, j and k and computing i=1; otherwise IDLE SHALL hold.
REQ-020 The per-byte sequence SHALL be RD_SI, LT_SI, RD_SJ, LT_SJ, WR_SI, WR_SJ, RD_F, LT_F, WR_OUT: exactly 9 cycles per byte.
REQ-021 Each RD_x state SHALL drive the address, and the following LT_x state SHALL latch s_data_in (and rom_data in LT_F) at its end.
REQ-022 RD_SI SHALL drive s_address=i; LT_SI SHALL latch si and compute j=j+si.
REQ-023 RD_SJ SHALL drive s_address=j; LT_SJ SHALL latch sj.
REQ-024 WR_SI SHALL drive s_address=i, s_data_out=sj, s_wr_en=1.
REQ-025 WR_SJ SHALL drive s_address=j, s_data_out=si, s_wr_en=1.
REQ-026 RD_F SHALL drive s_address=si+sj and rom_address=k.
REQ-027 WR_OUT SHALL drive ram_address=k, ram_data=f XOR enc, ram_wr_en=1.
REQ-028 After WR_OUT, if k=MSG_LEN-1 the FSM SHALL go to DONE; otherwise it SHALL increment k and i and go to RD_SI.
REQ-029 DONE SHALL assert fin_strobe for exactly one cycle and then return to IDLE.
REQ-030 fin_strobe SHALL be high in the cycle beginning 9*MSG_LEN clock edges after the edge that sampled start.
REQ-031 When i=j, the block SHALL perform both writes in order, leaving S[i] unchanged; no hazard logic is required.
REQ-032 The F read SHALL occur after both swap writes and therefore return post-swap S contents.
REQ-033 start SHALL be ignored in every state other than IDLE; an active run SHALL NOT be restarted.
REQ-034 s_wr_en and ram_wr_en SHALL be 0 in every state other than WR_SI, WR_SJ and WR_OUT respectively.
REQ-035 In states where an address output is not used, that output SHALL be driven to 0.

Reset
REQ-036 While rst=0, the block SHALL go immediately to IDLE and hold i, j, k, si, sj and f at 0.
REQ-037 While rst=0, all outputs SHALL be 0, including task_on, fin_strobe, s_wr_en and ram_wr_en.
REQ-038 After a reset asserted mid-run, the block SHALL produce no fin_strobe; after rst returns to 1, the block SHALL wait in IDLE for a new start.

Verification
REQ-039 The bench SHALL cover: identity S (S[x]=x), all-zero ROM, start pulse -> ram writes 02, 05, 07 at addresses 0, 1, 2; S[2]=03, S[3]=05, S[5]=02 after byte 2.
REQ-040 The bench SHALL cover: identity S, ROM[0]=0xFF -> ram[0]=0xFD, with the i=j=1 swap writing S[1]=01 twice.
REQ-041 The bench SHALL cover: start pulse with MSG_LEN=32 -> exactly 32 ram_wr_en pulses and fin_strobe high exactly 288 edges after start is sampled, with task_on high throughout the run.
REQ-042 The bench SHALL cover: start=1 held for 20 cycles mid-run -> no restart, with completion at the same cycle as in REQ-041.
REQ-043 The bench SHALL cover: rst=0 at cycle 100 of a run -> all outputs 0 immediately, no fin_strobe; a new start after release -> correct output from byte 0.
REQ-044 The bench SHALL cover: task1 -> task2a (key 000249) -> task2b chain -> ram contents match a software RC4 model byte-for-byte.
